// File: rtl/gpio_debouncer_pkg.sv
// Shared helpers for the GPIO debouncer: width derivation and default timing constants.
package gpio_debouncer_pkg;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int DEFAULT_TICK_DIV     = 100000;
    localparam int DEFAULT_STABLE_TICKS = 10;
    localparam int PRESCALE_W           = clog2_min1(DEFAULT_TICK_DIV);
    localparam int COUNT_W              = clog2_min1(DEFAULT_STABLE_TICKS);

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: the level flips only after STABLE_TICKS consecutive mismatching ticks,
// with a registered one-cycle rise/fall pulse on the cycle the level changes.
module debounce_channel
    import gpio_debouncer_pkg::*;
#(
    parameter int   STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter logic INIT         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_bit,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                 CNT_W     = clog2_min1(STABLE_TICKS);
    localparam logic [CNT_W-1:0]   LAST_TICK = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= INIT;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            // Any cycle of agreement restarts the filter, tick or not.
            if (sync_bit == level) begin
                count <= '0;
            end else if (tick) begin
                if (count == LAST_TICK) begin
                    level <= sync_bit;
                    count <= '0;
                    rise  <= sync_bit;
                    fall  <= ~sync_bit;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_debouncer.sv
// Synchronises raw pad inputs into io_mainClk and filters contact bounce per channel,
// sharing one sample-tick prescaler across all channels.
module gpio_debouncer
    import gpio_debouncer_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int               STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter logic [WIDTH-1:0] INIT         = '0
) (
    input  logic             io_mainClk,
    input  logic             io_asyncReset,
    input  logic [WIDTH-1:0] io_raw,
    output logic [WIDTH-1:0] io_debounced,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic             io_changed
);

    localparam int               PRE_W      = clog2_min1(TICK_DIV);
    localparam logic [PRE_W-1:0] LAST_PHASE = PRE_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PRE_W-1:0] prescale;
    logic             tick;

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            sync1 <= INIT;
            sync2 <= INIT;
        end else begin
            sync1 <= io_raw;
            sync2 <= sync1;
        end
    end

    assign tick = (prescale == LAST_PHASE);

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .INIT         (INIT[i])
        ) u_chan (
            .clk      (io_mainClk),
            .rst      (io_asyncReset),
            .sync_bit (sync2[i]),
            .tick     (tick),
            .level    (io_debounced[i]),
            .rise     (io_rise[i]),
            .fall     (io_fall[i])
        );
    end

    // Built purely from the pulse registers, so it lines up with them cycle for cycle.
    assign io_changed = |(io_rise | io_fall);

endmodule

// File: tb/tb_gpio_debouncer.sv
// Self-checking bench for gpio_debouncer: tick-counting reference model plus directed latency cases.
module tb_gpio_debouncer;

    localparam int TD = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] raw = 8'h00;
    logic [7:0] deb, rise, fall;
    logic       chg;
    logic       raw2 = 1'b0;
    logic       deb2, rise2, fall2, chg2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_debouncer #(.WIDTH(8), .TICK_DIV(TD), .STABLE_TICKS(ST), .INIT(8'h00)) dut (
        .io_mainClk    (clk),
        .io_asyncReset (rst),
        .io_raw        (raw),
        .io_debounced  (deb),
        .io_rise       (rise),
        .io_fall       (fall),
        .io_changed    (chg)
    );

    gpio_debouncer #(.WIDTH(1), .TICK_DIV(1), .STABLE_TICKS(1), .INIT(1'b0)) dut_fast (
        .io_mainClk    (clk),
        .io_asyncReset (rst),
        .io_raw        (raw2),
        .io_debounced  (deb2),
        .io_rise       (rise2),
        .io_fall       (fall2),
        .io_changed    (chg2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel flips at the edge where the number of sample ticks
    // inside its current unbroken mismatch run reaches ST.
    int         n_edge;
    logic [7:0] raw_hist[$];
    logic [7:0] m_level, m_rise, m_fall, s2;
    int         streak_start[8];
    bit         in_streak[8];

    initial begin
        m_level = '0; m_rise = '0; m_fall = '0; n_edge = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n_edge = 0;
                raw_hist.delete();
                m_level = '0; m_rise = '0; m_fall = '0;
                for (int i = 0; i < 8; i++) in_streak[i] = 1'b0;
            end else begin
                n_edge++;
                s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 8'h00;
                m_rise = '0; m_fall = '0;
                for (int i = 0; i < 8; i++) begin
                    if (s2[i] != m_level[i]) begin
                        if (!in_streak[i]) begin
                            in_streak[i]    = 1'b1;
                            streak_start[i] = n_edge;
                        end
                        if (n_edge / TD - (streak_start[i] - 1) / TD >= ST) begin
                            m_level[i]   = s2[i];
                            m_rise[i]    = s2[i];
                            m_fall[i]    = ~s2[i];
                            in_streak[i] = 1'b0;
                        end
                    end else begin
                        in_streak[i] = 1'b0;
                    end
                end
                raw_hist.push_back(raw);
                if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            end
        end
    end

    int cnt_rise[8];
    int cnt_fall_tot = 0;
    int cnt_chg = 0;

    initial begin
        for (int i = 0; i < 8; i++) cnt_rise[i] = 0;
        forever begin
            @(negedge clk);
            chk("model_debounced", deb, m_level);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_changed", chg, |(m_rise | m_fall));
            chk("rise_fall_exclusive", rise & fall, 0);
            for (int i = 0; i < 8; i++) cnt_rise[i] += rise[i];
            cnt_fall_tot += $countones(fall);
            cnt_chg += chg;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_level(input int ch, input logic val, output int k);
        k = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (deb[ch] === val) begin
                k = e;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int r3;
        int c0;
        int rise_sum;

        #1 rst = 1'b1;
        cyc(3);
        chk("reset_debounced", deb, 8'h00);
        chk("reset_rise", rise, 8'h00);
        chk("reset_changed", chg, 0);
        rst = 1'b0;

        // Quiet input through and after reset.
        cyc(50);
        chk("idle_debounced", deb, 8'h00);
        rise_sum = 0;
        for (int i = 0; i < 8; i++) rise_sum += cnt_rise[i];
        chk("idle_no_pulses", rise_sum + cnt_fall_tot + cnt_chg, 0);

        // Single clean rise on channel 0.
        raw[0] = 1'b1;
        wait_level(0, 1'b1, k);
        chk("rise0_latency_in_11_14", (k >= 11 && k <= 14), 1);
        chk("rise0_pulse", rise, 8'h01);
        chk("rise0_changed", chg, 1);
        chk("rise0_no_fall", fall, 8'h00);
        @(negedge clk);
        chk("rise0_pulse_cleared", rise, 8'h00);
        chk("rise0_changed_cleared", chg, 0);
        cyc(5);

        // Short glitch on channel 3 is swallowed.
        r3 = cnt_rise[3];
        raw[3] = 1'b1;
        cyc(5);
        raw[3] = 1'b0;
        cyc(30);
        chk("glitch_debounced", deb, 8'h01);
        chk("glitch_no_pulse", cnt_rise[3] - r3, 0);

        // Chatter every 3 cycles, then settle high.
        for (int j = 0; j < 14; j++) begin
            raw[3] = ~raw[3];
            cyc(3);
        end
        chk("chatter_debounced", deb, 8'h01);
        chk("chatter_no_pulse", cnt_rise[3] - r3, 0);
        raw[3] = 1'b1;
        wait_level(3, 1'b1, k);
        chk("settle_latency_in_11_14", (k >= 11 && k <= 14), 1);
        cyc(5);
        chk("settle_single_rise3", cnt_rise[3] - r3, 1);

        // All high, then several channels fall together.
        raw = 8'hFF;
        cyc(20);
        chk("all_high", deb, 8'hFF);
        c0 = cnt_chg;
        raw = 8'h5A;
        k = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (fall !== 8'h00) begin
                k = e;
                break;
            end
        end
        chk("multi_fall_latency_in_11_14", (k >= 11 && k <= 14), 1);
        chk("multi_fall_vector", fall, 8'hA5);
        chk("multi_fall_no_rise", rise, 8'h00);
        chk("multi_fall_changed", chg, 1);
        @(negedge clk);
        chk("multi_fall_debounced", deb, 8'h5A);
        chk("multi_fall_cleared", fall, 8'h00);
        cyc(20);
        chk("multi_fall_single_changed", cnt_chg - c0, 1);

        // Reset in the middle of filtering a rise on channel 1.
        raw = 8'h00;
        cyc(20);
        chk("pre_reset_low", deb, 8'h00);
        raw = 8'h02;
        cyc(10);
        rst = 1'b1;
        #1;
        chk("mid_reset_debounced", deb, 8'h00);
        chk("mid_reset_rise", rise, 8'h00);
        chk("mid_reset_changed", chg, 0);
        cyc(2);
        rst = 1'b0;
        // Sync2 valid after edge 2, ticks land on edges 4, 8, 12.
        wait_level(1, 1'b1, k);
        chk("post_reset_rise1_edge", k, 12);
        chk("post_reset_rise1_pulse", rise, 8'h02);
        cyc(5);

        // Unfiltered configuration: level follows input on the third edge.
        raw2 = 1'b1;
        k = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (deb2 === 1'b1) begin
                k = e;
                break;
            end
        end
        chk("fast_rise_edge", k, 3);
        chk("fast_rise_pulse", rise2, 1);
        chk("fast_rise_changed", chg2, 1);
        cyc(3);
        raw2 = 1'b0;
        k = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (deb2 === 1'b0) begin
                k = e;
                break;
            end
        end
        chk("fast_fall_edge", k, 3);
        chk("fast_fall_pulse", fall2, 1);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
